// File: rtl/stall_ctrl_pkg.sv
// Shared constants and types for the hazard/stall controller and the
// multiply/divide busy counter.
package stall_ctrl_pkg;

  // Tuse value meaning "this operand is not read by the instruction in D".
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Kind of multi-cycle operation launched from E.
  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_type_e;

  // Default busy lengths after a start in E.
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/stall_if.sv
// Stall interface: hazard information flowing from the D/E/M stages into the
// stall controller, and the hold/flush decisions flowing back out.
interface stall_if;
  import stall_ctrl_pkg::*;

  // Instruction in D
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_tuse_rs;
  logic [1:0]  D_tuse_rt;
  logic        D_is_md;
  // Instruction in E
  logic [4:0]  E_wa;
  logic [1:0]  E_tnew;
  logic        E_md_start;
  md_type_e    E_md_type;
  // Instruction in M
  logic [4:0]  M_wa;
  logic [1:0]  M_tnew;
  // Decisions
  logic        D_en;
  logic        PC_en;
  logic        E_flush;
  logic        md_busy;
  logic [31:0] stall_cnt;

  // The stall controller: consumes hazard info, produces hold/flush.
  modport master (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    input  E_wa, E_tnew, E_md_start, E_md_type,
    input  M_wa, M_tnew,
    output D_en, PC_en, E_flush, md_busy, stall_cnt
  );

  // The pipeline side: supplies hazard info, obeys hold/flush.
  modport slave (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    output E_wa, E_tnew, E_md_start, E_md_type,
    output M_wa, M_tnew,
    input  D_en, PC_en, E_flush, md_busy, stall_cnt
  );

endinterface

// File: rtl/md_busy_cnt.sv
// Loadable down-counter that marks the multiply/divide unit busy for a fixed
// number of cycles after a start. Also usable by the md unit to time its
// HI/LO writeback. CNT_W must be wide enough for the larger cycle count.
module md_busy_cnt
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     start,
  input  md_type_e md_type,
  output logic     busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  // Load on a start while idle; otherwise count down to zero. A start that
  // arrives while already busy is ignored so the running operation keeps its
  // timing.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (start && (cnt_q == '0)) begin
      cnt_q <= (md_type == MD_DIV) ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/stall_ctrl.sv
// Hazard/stall controller. Decides, in the same cycle, whether the
// instruction in D must wait: either one of its source registers is produced
// too late by E or M to be forwarded, or it touches the md unit while a
// multiply/divide is starting or still running. A stall holds F->D and the
// PC and turns the D->E slot into a bubble. A saturating counter records how
// many cycles were lost to stalls.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     reset,
  stall_if.master  bus
);

  logic        stall_rs;
  logic        stall_rt;
  logic        stall_md;
  logic        d_en;
  logic        md_busy;
  logic [31:0] stall_cnt_q;

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_cnt (
    .clk     (clk),
    .reset   (reset),
    .start   (bus.E_md_start),
    .md_type (bus.E_md_type),
    .busy    (md_busy)
  );

  // Hazard decision. A source register stalls only when a later stage will
  // write it and that result arrives after D needs it (tnew > tuse, unsigned);
  // anything arriving in time is handled by forwarding. $0 never stalls.
  // NOTE: combinational logic uses blocking assignments with a default for
  // every output first, so no path can leave a value held (no latch).
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    stall_md = 1'b0;

    if ((bus.D_rs != 5'd0) && (bus.D_tuse_rs != TUSE_NONE)) begin
      stall_rs = ((bus.D_rs == bus.E_wa) && (bus.E_tnew > bus.D_tuse_rs)) ||
                 ((bus.D_rs == bus.M_wa) && (bus.M_tnew > bus.D_tuse_rs));
    end

    if ((bus.D_rt != 5'd0) && (bus.D_tuse_rt != TUSE_NONE)) begin
      stall_rt = ((bus.D_rt == bus.E_wa) && (bus.E_tnew > bus.D_tuse_rt)) ||
                 ((bus.D_rt == bus.M_wa) && (bus.M_tnew > bus.D_tuse_rt));
    end

    // The md unit is occupied from the start cycle in E until the counter
    // drains.
    stall_md = bus.D_is_md && (bus.E_md_start || md_busy);
  end

  assign d_en        = stall_rs | stall_rt | stall_md;
  assign bus.D_en    = d_en;
  assign bus.E_flush = d_en;
  assign bus.PC_en   = ~d_en;
  assign bus.md_busy = md_busy;

  // Count stalled cycles; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (d_en && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl. Inputs change on the falling edge;
// outputs are sampled 2 ns later, well away from the rising edge. Each
// scenario pushes the expected outputs to a scoreboard queue when it drives
// stimulus and pops/compares them once the DUT has settled.
module tb_stall_ctrl;
  import stall_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  stall_if sif ();

  stall_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  ctl;   // {D_en, E_flush, PC_en, md_busy}
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    int rs, tuse_rs, rt, tuse_rt, e_wa, e_tnew, m_wa, m_tnew;
    bit stall;
  } fwd_t;

  exp_t        sb[$];
  int          total   = 0;
  int          bad     = 0;
  logic [31:0] exp_cnt = '0;

  function automatic logic [3:0] ctl_of(logic d_en, logic busy);
    return {d_en, d_en, ~d_en, busy};
  endfunction

  task automatic push_exp(string tag, logic d_en, logic busy);
    exp_t e;
    e.tag = tag;
    e.ctl = ctl_of(d_en, busy);
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic drive_haz(int rs, int tuse_rs, int rt, int tuse_rt,
                           int e_wa, int e_tnew, int m_wa, int m_tnew);
    sif.D_rs      = 5'(rs);
    sif.D_tuse_rs = 2'(tuse_rs);
    sif.D_rt      = 5'(rt);
    sif.D_tuse_rt = 2'(tuse_rt);
    sif.E_wa      = 5'(e_wa);
    sif.E_tnew    = 2'(e_tnew);
    sif.M_wa      = 5'(m_wa);
    sif.M_tnew    = 2'(m_tnew);
  endtask

  task automatic clear_inputs();
    drive_haz(0, 0, 0, 0, 0, 0, 0, 0);
    sif.D_is_md    = 1'b0;
    sif.E_md_start = 1'b0;
    sif.E_md_type  = MD_MULT;
  endtask

  task automatic test_reset();
    exp_t e;
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #2;
    push_exp("reset_state", 1'b0, 1'b0);
    e = sb.pop_front(); total++;
    if ({sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy} !== e.ctl || sif.stall_cnt !== e.cnt) begin
      bad++;
      $display("FAIL %s: got ctl=%b cnt=%h, want ctl=%b cnt=%h", e.tag,
               {sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy}, sif.stall_cnt, e.ctl, e.cnt);
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    string tags [3] = '{"load_use", "load_use_r0", "load_use_clear"};
    bit    stl  [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0)      drive_haz(5, 0, 0, 3, 5, 2, 0, 0);
      else if (i == 1) drive_haz(0, 0, 0, 3, 5, 2, 0, 0);
      else             clear_inputs();
      #2;
      push_exp(tags[i], stl[i], 1'b0);
      e = sb.pop_front(); total++;
      if ({sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy} !== e.ctl || sif.stall_cnt !== e.cnt) begin
        bad++;
        $display("FAIL %s: got ctl=%b cnt=%h, want ctl=%b cnt=%h", e.tag,
                 {sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy}, sif.stall_cnt, e.ctl, e.cnt);
      end
      if (stl[i]) exp_cnt++;
    end
  endtask

  task automatic test_forward();
    exp_t e;
    fwd_t tbl [9];
    tbl = '{
      '{0, 3,  7, 1,  0, 0,  7, 1, 1'b0},  // M result in time for rt
      '{0, 3,  7, 3,  7, 2,  0, 0, 1'b0},  // rt unused
      '{0, 3,  7, 0,  0, 0,  7, 1, 1'b1},  // M result late for rt
      '{9, 1,  0, 3,  9, 1,  0, 0, 1'b0},  // tnew == tuse forwards
      '{9, 1,  0, 3,  9, 2,  0, 0, 1'b1},  // tnew one past tuse
      '{9, 2,  0, 3,  0, 0,  9, 3, 1'b1},  // unsigned compare 3 > 2
      '{0, 0,  0, 0,  0, 2,  0, 2, 1'b0},  // $0 never stalls
      '{4, 0,  4, 0,  6, 2,  3, 2, 1'b0},  // no register match
      '{0, 3, 12, 1, 12, 2, 12, 0, 1'b1}   // E match late, M match fine
    };
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_haz(tbl[i].rs, tbl[i].tuse_rs, tbl[i].rt, tbl[i].tuse_rt,
                tbl[i].e_wa, tbl[i].e_tnew, tbl[i].m_wa, tbl[i].m_tnew);
      #2;
      push_exp($sformatf("forward_%0d", i), tbl[i].stall, 1'b0);
      e = sb.pop_front(); total++;
      if ({sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy} !== e.ctl || sif.stall_cnt !== e.cnt) begin
        bad++;
        $display("FAIL %s: got ctl=%b cnt=%h, want ctl=%b cnt=%h", e.tag,
                 {sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy}, sif.stall_cnt, e.ctl, e.cnt);
      end
      if (tbl[i].stall) exp_cnt++;
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_mult();
    exp_t e;
    bit   busy;
    // Start cycle: md hazard from E_md_start alone, counter still idle.
    @(negedge clk);
    sif.E_md_start = 1'b1;
    sif.E_md_type  = MD_MULT;
    sif.D_is_md    = 1'b1;
    #2;
    push_exp("mult_start", 1'b1, 1'b0);
    e = sb.pop_front(); total++;
    if ({sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy} !== e.ctl || sif.stall_cnt !== e.cnt) begin
      bad++;
      $display("FAIL %s: got ctl=%b cnt=%h, want ctl=%b cnt=%h", e.tag,
               {sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy}, sif.stall_cnt, e.ctl, e.cnt);
    end
    exp_cnt++;
    // Busy for exactly MULT_N cycles after the start edge, free on the next.
    for (int i = 1; i <= MULT_N + 1; i++) begin
      @(negedge clk);
      sif.E_md_start = 1'b0;
      #2;
      busy = (i <= MULT_N);
      push_exp($sformatf("mult_cycle_%0d", i), busy, busy);
      e = sb.pop_front(); total++;
      if ({sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy} !== e.ctl || sif.stall_cnt !== e.cnt) begin
        bad++;
        $display("FAIL %s: got ctl=%b cnt=%h, want ctl=%b cnt=%h", e.tag,
                 {sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy}, sif.stall_cnt, e.ctl, e.cnt);
      end
      if (busy) exp_cnt++;
    end
    sif.D_is_md = 1'b0;
  endtask

  task automatic test_div_reset();
    exp_t e;
    bit   busy;
    // Divide start, then reset asserted mid-cycle after 4 busy cycles.
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      sif.E_md_start = (i == 0);
      sif.E_md_type  = MD_DIV;
      #2;
      push_exp($sformatf("div_pre_reset_%0d", i), 1'b0, (i != 0));
      e = sb.pop_front(); total++;
      if ({sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy} !== e.ctl || sif.stall_cnt !== e.cnt) begin
        bad++;
        $display("FAIL %s: got ctl=%b cnt=%h, want ctl=%b cnt=%h", e.tag,
                 {sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy}, sif.stall_cnt, e.ctl, e.cnt);
      end
    end
    #1 reset = 1'b0;
    #1;
    exp_cnt = '0;
    push_exp("div_async_reset", 1'b0, 1'b0);
    e = sb.pop_front(); total++;
    if ({sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy} !== e.ctl || sif.stall_cnt !== e.cnt) begin
      bad++;
      $display("FAIL %s: got ctl=%b cnt=%h, want ctl=%b cnt=%h", e.tag,
               {sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy}, sif.stall_cnt, e.ctl, e.cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    // Full divide; a second start at cycle 3 must not extend it.
    for (int i = 0; i <= DIV_N + 1; i++) begin
      @(negedge clk);
      sif.E_md_start = (i == 0) || (i == 3);
      sif.E_md_type  = (i == 0) ? MD_DIV : MD_MULT;
      #2;
      busy = (i >= 1) && (i <= DIV_N);
      push_exp($sformatf("div_cycle_%0d", i), 1'b0, busy);
      e = sb.pop_front(); total++;
      if ({sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy} !== e.ctl || sif.stall_cnt !== e.cnt) begin
        bad++;
        $display("FAIL %s: got ctl=%b cnt=%h, want ctl=%b cnt=%h", e.tag,
                 {sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy}, sif.stall_cnt, e.ctl, e.cnt);
      end
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    // Data hazard and md hazard together: one stall, one count per cycle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        drive_haz(5, 0, 0, 3, 5, 2, 0, 0);
        sif.D_is_md    = 1'b1;
        sif.E_md_start = 1'b1;
        sif.E_md_type  = MD_MULT;
      end else begin
        drive_haz(0, 0, 0, 0, 0, 0, 0, 0);
        sif.E_md_start = 1'b0;
        sif.D_is_md    = (i == 1);
      end
      #2;
      push_exp($sformatf("combined_%0d", i), (i < 2), (i != 0));
      e = sb.pop_front(); total++;
      if ({sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy} !== e.ctl || sif.stall_cnt !== e.cnt) begin
        bad++;
        $display("FAIL %s: got ctl=%b cnt=%h, want ctl=%b cnt=%h", e.tag,
                 {sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy}, sif.stall_cnt, e.ctl, e.cnt);
      end
      if (i < 2) exp_cnt++;
    end
    // Let the multiply drain before the next scenario.
    repeat (MULT_N) @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_saturation();
    exp_t e;
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt_q;
    drive_haz(5, 0, 0, 3, 5, 2, 0, 0);
    exp_cnt = 32'hFFFF_FFFD;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #2;
      end
      push_exp($sformatf("saturate_%0d", i), 1'b1, 1'b0);
      e = sb.pop_front(); total++;
      if ({sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy} !== e.ctl || sif.stall_cnt !== e.cnt) begin
        bad++;
        $display("FAIL %s: got ctl=%b cnt=%h, want ctl=%b cnt=%h", e.tag,
                 {sif.D_en, sif.E_flush, sif.PC_en, sif.md_busy}, sif.stall_cnt, e.ctl, e.cnt);
      end
      if (exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
    end
    @(negedge clk);
    clear_inputs();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_mult();
    test_div_reset();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Run-time bound in case the sequence ever stalls.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Hazard/stall controller: the producer side of the stall interface whose consumer is the F→D pipeline register.
- Drives the F→D register hold (`D_en`: 1 = hold), the PC hold, and the D→E bubble insert.
- Decision inputs:
  - Tuse/Tnew data-hazard comparison for the instruction in D against E and M.
  - A multi-cycle multiply/divide busy counter.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5: busy cycles after a mult/multu start in E
- DIV_CYCLES, 10: busy cycles after a div/divu start in E
- CNT_W, 4: md counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- D_rs  in  5  rs of instruction in D
- D_rt  in  5  rt of instruction in D
- D_tuse_rs  in  2  cycles until D needs rs (0..2; 3 = unused)
- D_tuse_rt  in  2  cycles until D needs rt (0..2; 3 = unused)
- D_is_md  in  1  D instruction uses md unit (mult/div/mfhi/mflo/mthi/mtlo)
- E_wa  in  5  destination reg of E instruction (0 = none)
- E_tnew  in  2  cycles until E result is available
- M_wa  in  5  destination reg of M instruction (0 = none)
- M_tnew  in  2  cycles until M result is available
- E_md_start  in  1  E instruction is mult/multu/div/divu (one cycle)
- E_md_type  in  1  0 = mult, 1 = div (valid with E_md_start)
- D_en  out  1  F→D register hold (1 = hold)
- PC_en  out  1  PC write enable (= ~D_en)
- E_flush  out  1  clear D→E register to nop (= D_en)
- md_busy  out  1  md counter nonzero
- stall_cnt  out  32  saturating count of stalled cycles

Behaviour:
- Reset (reset = 0, asynchronous, any time including mid-divide):
  - md_cnt ← 0, stall_cnt ← 0 immediately.
  - md_busy = 0.
  - D_en/E_flush = 0 and PC_en = 1 whenever all hazard inputs are idle.
- Data hazard, rs (combinational): `stall_rs` = (D_rs != 0) && (D_tuse_rs != 3) && [((D_rs == E_wa) && (E_tnew > D_tuse_rs)) || ((D_rs == M_wa) && (M_tnew > D_tuse_rs))].
- Data hazard, rt: `stall_rt` is the same equation using D_rt and D_tuse_rt.
- Register 0 never stalls. A match with tnew ≤ tuse never stalls; it is covered by forwarding.
- md hazard (combinational): `stall_md` = D_is_md && (E_md_start || md_busy).
- Outputs:
  - D_en = stall_rs | stall_rt | stall_md.
  - E_flush = D_en.
  - PC_en = ~D_en.
  - All are purely combinational from inputs and md_cnt; no added latency.
- md counter (sequential, rising clk):
  - E_md_start && md_cnt == 0: load MULT_CYCLES (type 0) or DIV_CYCLES (type 1).
  - Otherwise, if md_cnt != 0: decrement by 1.
  - E_md_start while md_cnt != 0 (illegal; prevented by stall_md): the start is ignored and decrement continues.
  - md_busy = (md_cnt != 0), decoded from the register.
  - A mult started in E at edge k gives md_busy = 1 for exactly MULT_CYCLES cycles after edge k.
- stall_cnt:
  - Increments by 1 at each rising clk where D_en = 1.
  - Holds at 32'hFFFF_FFFF; no wrap.
- Simultaneous events: an md hazard together with a data hazard gives a single stall; stall_cnt increments once.
- Width rule: tnew/tuse comparison is unsigned 2-bit.

Decomposition:
- Shared package constants:
  - TUSE_NONE = 2'd3
  - MD_MULT = 1'b0, MD_DIV = 1'b1
  - MULT_CYCLES / DIV_CYCLES defaults
- Sub-module `md_busy_cnt`:
  - Contents: loadable down-counter with busy flag (clk, reset, start, type → busy).
  - Rationale: it is reusable by the md unit itself to time HI/LO writeback.
- Hazard equations stay inline.

Test Plan:
- Reset release, all inputs 0 → D_en = 0, PC_en = 1, E_flush = 0, md_busy = 0, stall_cnt = 0. Asserting reset mid-cycle clears md_cnt and stall_cnt without waiting for clk.
- Load-use hazard:
  - Stimulus: D_rs = 5, D_tuse_rs = 0, E_wa = 5, E_tnew = 2.
  - Response: D_en = 1, E_flush = 1, PC_en = 0; stall_cnt 0→1 at next edge.
  - With D_rs = 0 under the same conditions: D_en = 0.
- No stall when forwardable, both cases giving D_en = 0:
  - D_rt = 7, D_tuse_rt = 1, M_wa = 7, M_tnew = 1.
  - D_tuse_rt = 3 with E_wa = 7, E_tnew = 2.
- Multiply timing:
  - Stimulus: E_md_start = 1, E_md_type = 0 for one cycle; D_is_md = 1.
  - Response: D_en = 1 in the start cycle and for 5 following cycles; md_busy high exactly 5 cycles; D_en = 0 on the 6th.
- Divide and reset mid-operation:
  - Stimulus: div start, then reset = 0 after 4 cycles.
  - Response: md_busy drops immediately. Without reset, md_busy lasts 10 cycles; a second E_md_start while busy does not extend it.
- Saturation: preload stall_cnt near max (force), then hold D_en = 1 for 3 cycles → stall_cnt stops at 32'hFFFF_FFFF.
